multiplier_issue_ctrl: RTL
==========================

Name: multiplier_issue_ctrl

Overview:
Upstream feeder and result catcher for the iterative 32x32 multiplier. Buffers operand pairs from a valid/ready producer in a small FIFO and issues them one at a time to the multiplier as a single-cycle valid_in pulse. Holds the operands stable until the multiplier's valid_out, then presents the 64-bit product on a valid/ready output. Results leave in issue order.

Parameters:
WIDTH, 32, operand width; product width is 2*WIDTH.
FIFO_DEPTH, 4, operand FIFO entries; must be a power of 2 and at least 2.
SETTLE_CYCLES, 72, post-reset quiet period; must be at least the multiplier's worst-case latency.
TIMEOUT_CYCLES, 128, WAIT watchdog limit; used only with MUL_TIMEOUT_EN.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out_r  out  2*WIDTH  product
mul_valid_in  out  1  one-cycle start pulse to multiplier
mul_a  out  WIDTH  operand a to multiplier
mul_b  out  WIDTH  operand b to multiplier
mul_valid_out  in  1  multiplier done
mul_r  in  2*WIDTH  multiplier product
timeout_err  out  1  sticky watchdog flag; tied 0 without the macro

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); the polarity and synchronicity are fixed.
- After a reset edge: FIFO empty, in_ready=1, out_valid=0, out_r=0, mul_valid_in=0, mul_a=0, mul_b=0, timeout_err=0, state=SETTLE with the counter cleared.
- The multiplier has no reset, so an operation in flight across a reset must be discarded.
- FIFO push: occurs when in_valid && in_ready. in_ready = !full. A pop in the same cycle does not free a slot for a push while full. Push and pop in the same cycle when not full: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- SETTLE: FIFO may still accept pushes. No issue occurs. mul_valid_out is ignored. After SETTLE_CYCLES cycles, go to IDLE.
- IDLE: if the FIFO is not empty and out_valid=0, pop the head into mul_a/mul_b and go to ISSUE. mul_valid_out is ignored.
- ISSUE: lasts exactly one cycle with mul_valid_in=1, then go to WAIT. mul_valid_out is ignored in this cycle.
- WAIT: mul_valid_in=0 and mul_a/mul_b are held constant. On mul_valid_out=1: capture out_r<=mul_r, set out_valid=1 on the next cycle, and go to IDLE.
- Output register: out_valid stays high and out_r stays stable until out_ready=1. out_valid clears on that edge.
- A new issue can occur no earlier than the cycle after the drain edge; there is no issue while a product is pending.
- Latency from a push into an empty FIFO (accepted at edge k, in IDLE, output empty): mul_valid_in is high during cycle k+1. out_valid rises one cycle after mul_valid_out is sampled in WAIT.
- mul_valid_in is never asserted outside ISSUE and at most once per popped entry.
- Reset mid-WAIT or mid-SETTLE: the operation is abandoned, the FIFO is flushed, and the sequence restarts at SETTLE.

Optional Feature:
MUL_TIMEOUT_EN defined:
- WAIT counts cycles from entry.
- If TIMEOUT_CYCLES elapse without mul_valid_out: set timeout_err=1 (sticky until reset), drop the operation with no out_valid, and go to SETTLE.
- The SETTLE counter is reused for the watchdog.
Macro undefined:
- WAIT waits indefinitely.
- timeout_err is constant 0.

Decomposition:
- Package mul_issue_pkg holds the state enum (SETTLE, IDLE, ISSUE, WAIT) and default-width constants.
- Sub-module operand_fifo: parameterised width 2*WIDTH and depth, with push/pop/full/empty. The FSM, output register and counter stay in multiplier_issue_ctrl.

Test Plan:
1. Reset, wait SETTLE_CYCLES, push a=3, b=5 with out_ready=1 -> exactly one mul_valid_in pulse, then out_valid=1 with out_r=15, then out_valid drops.
2. Push a=32'hFFFFFFFF, b=32'hFFFFFFFF -> mul_a/mul_b unchanged across all of WAIT, and out_r=64'hFFFFFFFE00000001.
3. Hold out_ready=0 with one product pending, then push 5 pairs -> 4 accepted and in_ready=0. No mul_valid_in for 200 cycles and out_r stays stable. Releasing out_ready yields all products in push order.
4. Push and pop in the same cycle at count 3 -> count stays 3. At full with pop, a push in the same cycle is refused.
5. Assert reset during WAIT, then drive a stray mul_valid_out 10 cycles later -> out_valid stays 0 and there is no mul_valid_in for SETTLE_CYCLES. The next pair (7x6) returns 42.
6. With MUL_TIMEOUT_EN, TIMEOUT_CYCLES=16 and a stub multiplier that never responds -> timeout_err=1 after 16 WAIT cycles, no out_valid. After a 2x2 push and a working stub, out_r=4 and timeout_err stays 1.

Source files
------------

// File: rtl/mul_issue_pkg.sv
// Shared types and default sizes for the multiplier issue controller.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package mul_issue_pkg;

    // SETTLE: post-reset quiet period, IDLE: look for work,
    // ISSUE: one-cycle start pulse, WAIT: hold operands until the multiplier answers.
    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        IDLE   = 2'd1,
        ISSUE  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam int DEF_WIDTH          = 32;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_SETTLE_CYCLES  = 72;
    localparam int DEF_TIMEOUT_CYCLES = 128;

endpackage

// File: rtl/operand_fifo.sv
// Small circular operand buffer: push/pop with full/empty, head word visible on pop_dat.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: push is ignored while full, even if a pop happens in the same cycle.
//
// Ports: clk/reset (sync, active-high), push/push_dat write side,
//        pop/pop_dat read side (pop_dat is the current head), full/empty status.
module operand_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // Gate on the registered status so a same-cycle pop cannot make room for a push.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty/full are governed by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/multiplier_issue_ctrl.sv
// Feeds operand pairs to an iterative multiplier one at a time and catches the product.
// Latency: push into an empty FIFO at edge k -> mul_valid_in during cycle k+1; out_valid one cycle after mul_valid_out.
// Backpressure: in_ready = FIFO not full; no new issue while a product waits for out_ready.
//
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_a/in_b operand input;
//        out_valid/out_ready/out_r product output; mul_valid_in/mul_a/mul_b to the multiplier;
//        mul_valid_out/mul_r from the multiplier; timeout_err sticky watchdog flag.
// Build option: define MUL_TIMEOUT_EN to enable the WAIT watchdog (timeout_err is 0 otherwise).
module multiplier_issue_ctrl
    import mul_issue_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_r,
    output logic               mul_valid_in,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_valid_out,
    input  logic [2*WIDTH-1:0] mul_r,
    output logic               timeout_err
);

    localparam int PW      = 2 * WIDTH;
    // One counter serves both the settle period and the WAIT watchdog.
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [PW-1:0]    fifo_head;

    assign in_ready = !fifo_full;
    // Only one product may be outstanding: hold off while out_r is still undelivered.
    assign fifo_pop = (state == IDLE) && !fifo_empty && !out_valid;

    operand_fifo #(
        .DW    (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_operand_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (in_valid),
        .push_dat ({in_a, in_b}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // The multiplier itself is not reset; starting in SETTLE lets any
            // operation still in flight finish and be ignored.
            state        <= SETTLE;
            cnt          <= '0;
            mul_valid_in <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            out_valid    <= 1'b0;
            out_r        <= '0;
        end else begin
            mul_valid_in <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (fifo_pop) begin
                        mul_a        <= fifo_head[PW-1:WIDTH];
                        mul_b        <= fifo_head[WIDTH-1:0];
                        mul_valid_in <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    // mul_a/mul_b are left untouched so the multiplier sees stable operands.
                    if (mul_valid_out) begin
                        out_r     <= mul_r;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
`ifdef MUL_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abandon the operation; SETTLE absorbs a late answer.
                        state <= SETTLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= SETTLE;
            endcase
        end
    end

`ifdef MUL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if ((state == WAIT) && !mul_valid_out &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
